audio_capture: RTL
==================

# audio_capture

I2S receive front end that feeds the `audio_engine` audio RAM. It generates I2S bit clock and word select, deserializes NLINES stereo data lines, and writes each 16-bit sample into a circular frame buffer through the engine's audio RAM write port. On each completed frame it publishes the frame index and pulses `frame_done` so the engine can run its MAC program. If a frame completes while the engine is still busy, a sticky overrun flag is set.

## Interface
- `NLINES`, 4: number of I2S serial data inputs; each carries stereo, giving 2*NLINES channels.
- `FRAMES`, 32: frames in the circular buffer; power of two, matches the engine's 5-bit offset field.
- `CK_DIV`, 4: `sck` toggles every CK_DIV `ck` cycles, so the `sck` period is 2*CK_DIV `ck` cycles.
- `ck` in 1: system clock. One clock only.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: capture enable.
- `sck` out 1: I2S bit clock, registered.
- `ws` out 1: I2S word select, registered; 0 = left, 1 = right.
- `sd` in NLINES: I2S serial data, one bit per line.
- `wr_en` out 1: audio RAM write strobe.
- `wr_addr` out 9: {frame[4:0], chan[3:0]}, where chan = 2*line + (ws of slot).
- `wr_data` out 16: two's-complement sample, MSB-first as received.
- `frame_ptr` out 5: index of the most recently completed frame.
- `frame_done` out 1: one-cycle pulse when a frame is complete.
- `engine_busy` in 1: engine is executing its program.
- `overrun` out 1: sticky flag, set when a frame completes while the engine is busy.
- `overrun_clr` in 1: clears `overrun`.

## Operation
- Divider `div` counts 0..CK_DIV-1. At terminal count `sck` toggles.
  - Rise event: the edge where `sck` goes 0→1.
  - Fall event: the edge where `sck` goes 1→0.
- `bit_cnt` (6 bits, 0..63) increments on each fall event and wraps 63→0. `ws` is registered as `bit_cnt[5]` at the same edge.
- Sampling follows I2S one-bit delay.
  - On a rise event with `bit_cnt[4:0]` in 1..16, `sd[n]` is shifted into `shreg[n]` (left shift, MSB first).
  - Slot bits 0 and 17..31 are ignored.
- Write burst starts on the fall event that ends `bit_cnt[4:0]==16`.
  - On the next NLINES consecutive `ck` cycles, `wr_en`=1 with line = 0..NLINES-1.
  - `wr_addr` = {wr_frame, 2*line + bit_cnt[5] of the completed slot}; `wr_data` = `shreg[line]`.
  - `shreg` contents are frozen until the burst completes. The burst finishes long before the next slot's bit 1, since NLINES < 2*CK_DIV*16.
- Frame completion happens on the cycle after the last write of a right-slot burst:
  - `frame_ptr` ← `wr_frame`;
  - `frame_done` = 1 for one cycle;
  - `wr_frame` ← `wr_frame`+1 mod FRAMES (31→0).
- Overrun:
  - Set when `frame_done` fires while `engine_busy`=1.
  - Cleared when `overrun_clr`=1.
  - If set and clear coincide, set wins.
- Enable:
  - With `en`=0, `div`, `bit_cnt`, `sck` and `ws` are held at 0; no sampling; `wr_en`=0.
  - A burst in progress when `en` falls is abandoned. A partial frame never raises `frame_done`.
  - `wr_frame` and `frame_ptr` are retained.
  - When `en` rises, counting restarts at `bit_cnt`=0, div=0.

## Timing
- Reset values: `sck`=0, `ws`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_ptr`=0, `frame_done`=0, `overrun`=0. Internally, `wr_frame`=0 and `shreg`=0.
- Reset mid-burst aborts the burst immediately. The next cycle after `rst` falls behaves as a fresh start when `en`=1.
- Frame period: 64 × 2·CK_DIV `ck` cycles (512 with defaults).
- Write latency: `wr_en` of line 0 is asserted one `ck` cycle after the fall event ending slot bit 16.
- `frame_done` comes one cycle after the last right-slot write. It never coincides with `wr_en`.
- `wr_addr`, `wr_data` and `wr_en` are registered and change together. The engine samples them on its clock edge, with no handshake. The write port is always ready.

## Test plan
- Reset/idle: hold `rst` for 4 cycles, then keep `en`=0 for 200 cycles → all outputs stay 0 and `sck` never toggles.
- Single frame: `en`=1; drive left 0x1234 and right 0xABCD on `sd[0]`, 0x8001/0x7FFE on `sd[1]`, zeros elsewhere → writes {0,0}=0x1234, {0,1}=0xABCD, {0,2}=0x8001, {0,3}=0x7FFE, others 0. Then `frame_done` pulses once, `frame_ptr`=0, and the next frame writes to frame 1.
- Bit alignment: drive a 1 only at slot bit 0 and bit 17 → every written sample is 0x0000. Drive a 1 only at slot bit 1 → 0x8000. Drive a 1 only at slot bit 16 → 0x0001.
- Wrap-around: run 33 frames → the `frame_ptr` sequence reaches 31, then 0. The frame 32 writes use `wr_addr[8:4]`=0.
- Overrun: `engine_busy`=1 at `frame_done` → `overrun`=1 and stays set over 3 frames. Assert `overrun_clr` on the same cycle as a new busy `frame_done` → `overrun` stays 1. A lone clear → 0.
- Enable drop mid-frame: `en`=0 at `bit_cnt`=40 → no further `wr_en`, no `frame_done`, and `frame_ptr` is unchanged. Re-enable → `ws` restarts at 0 and the next complete frame uses the next `wr_frame`.

Source files
------------

// File: rtl/audio_capture.sv
// audio_capture: I2S receive front end. Generates sck/ws, deserializes NLINES
// stereo lines and writes each 16-bit sample into a circular frame buffer in
// the audio engine RAM, then announces each completed frame.
//
// Write port: wr_en is the valid strobe for wr_addr/wr_data and the RAM side is
// always ready, so every cycle with wr_en=1 is a completed write. There is no
// back-pressure and no ready signal.
module audio_capture #(
    parameter int NLINES = 4,
    parameter int FRAMES = 32,
    parameter int CK_DIV = 4,
    localparam int FW    = $clog2(FRAMES)
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              en,
    output logic              sck,
    output logic              ws,
    input  logic [NLINES-1:0] sd,
    output logic              wr_en,
    output logic [FW+3:0]     wr_addr,
    output logic [15:0]       wr_data,
    output logic [FW-1:0]     frame_ptr,
    output logic              frame_done,
    input  logic              engine_busy,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int DW = (CK_DIV > 1) ? $clog2(CK_DIV) : 1;
    localparam int LW = (NLINES > 1) ? $clog2(NLINES) : 1;

    logic [DW-1:0] div;
    logic [5:0]    bit_cnt;
    logic [5:0]    bit_cnt_nxt;
    logic [15:0]   shreg [NLINES];
    logic          burst_on;
    logic          burst_right;
    logic [LW-1:0] line_idx;
    logic          done_pend;
    logic [FW-1:0] wr_frame;

    logic div_tc;
    logic rise_ev;
    logic fall_ev;
    logic sample_bit;
    logic burst_last;

    assign div_tc      = (div == DW'(CK_DIV - 1));
    assign rise_ev     = en && div_tc && !sck;
    assign fall_ev     = en && div_tc && sck;
    assign bit_cnt_nxt = bit_cnt + 6'd1;
    // One-bit I2S delay: data bits live in slot positions 1..16.
    assign sample_bit  = (bit_cnt[4:0] != 5'd0) && (bit_cnt[4:0] <= 5'd16);
    assign burst_last  = (line_idx == LW'(NLINES - 1));

    // Bit clock divider, slot bit counter and word select.
    always_ff @(posedge ck) begin
        if (rst || !en) begin
            div     <= '0;
            sck     <= 1'b0;
            bit_cnt <= '0;
            ws      <= 1'b0;
        end else if (div_tc) begin
            div <= '0;
            sck <= ~sck;
            if (sck) begin
                bit_cnt <= bit_cnt_nxt;
                ws      <= bit_cnt_nxt[5];
            end
        end else begin
            div <= div + DW'(1);
        end
    end

    // Shift in the data bits of each line, MSB first, on sck rise events.
    always_ff @(posedge ck) begin
        if (rst) begin
            for (int n = 0; n < NLINES; n++) shreg[n] <= '0;
        end else if (rise_ev && sample_bit) begin
            for (int n = 0; n < NLINES; n++) shreg[n] <= {shreg[n][14:0], sd[n]};
        end
    end

    // Write burst: one line per cycle after the slot's last data bit ends.
    always_ff @(posedge ck) begin
        if (rst) begin
            burst_on    <= 1'b0;
            burst_right <= 1'b0;
            line_idx    <= '0;
            done_pend   <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else if (!en) begin
            // Disabling abandons any burst and any pending frame completion.
            burst_on  <= 1'b0;
            done_pend <= 1'b0;
            wr_en     <= 1'b0;
        end else begin
            wr_en     <= burst_on;
            done_pend <= 1'b0;
            if (burst_on) begin
                wr_addr <= {wr_frame, 4'({line_idx, burst_right})};
                wr_data <= shreg[line_idx];
                if (burst_last) begin
                    burst_on  <= 1'b0;
                    done_pend <= burst_right;
                end else begin
                    line_idx <= line_idx + LW'(1);
                end
            end else if (fall_ev && bit_cnt[4:0] == 5'd16) begin
                burst_on    <= 1'b1;
                burst_right <= bit_cnt[5];
                line_idx    <= '0;
            end
        end
    end

    // Frame completion, circular frame index and sticky overrun flag.
    always_ff @(posedge ck) begin
        if (rst) begin
            frame_done <= 1'b0;
            frame_ptr  <= '0;
            wr_frame   <= '0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= en && done_pend;
            if (en && done_pend) begin
                frame_ptr <= wr_frame;
                wr_frame  <= wr_frame + FW'(1);
            end
            // A new overrun takes priority over a simultaneous clear.
            if (frame_done && engine_busy) overrun <= 1'b1;
            else if (overrun_clr)          overrun <= 1'b0;
        end
    end

endmodule
